row_ram_responder: RTL and testbench

ROW_RAM_RESPONDER -- requirements
Module: row_ram_responder

---
 rtl/row_ram_responder.sv | 95 +++++++++
 tb/tb_row_ram_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/row_ram_responder.sv
// Dual-read / single-write row memory with a power-up clearing sweep.
// Reads are registered and see same-cycle writes (write-through).
module row_ram_responder #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256,
  parameter int DEPTH  = 2048
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WriteReq,
  input  logic [DATA_W-1:0] WriteBus,
  output logic [DATA_W-1:0] ReadBus1,
  output logic [DATA_W-1:0] ReadBus2,
  output logic              Ready
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state;
  state_t nextState;

  logic [ADDR_W-1:0] count;
  logic              lastRow;

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;

  logic [DATA_W-1:0] mem [DEPTH];

  assign lastRow = (count == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      count <= '0;
      Ready <= 1'b0;
    end else begin
      state <= nextState;
      Ready <= (nextState == RUN);
      if (state == INIT && !lastRow) begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    nextState = state;
    memWe     = 1'b0;
    memAddr   = count;
    memData   = '0;
    unique case (state)
      INIT: begin
        memWe = 1'b1;
        if (lastRow) begin
          nextState = RUN;
        end
      end
      RUN: begin
        memWe   = WE;
        memAddr = WriteReq;
        memData = WriteBus;
      end
    endcase
  end

  // Storage has no reset; the sweep is what clears it.
  always_ff @(posedge clock) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ReadBus1 <= '0;
      ReadBus2 <= '0;
    end else if (state == RUN) begin
      ReadBus1 <= (WE && WriteReq == ReadAddress1) ?
                  WriteBus : mem[ReadAddress1];
      ReadBus2 <= (WE && WriteReq == ReadAddress2) ?
                  WriteBus : mem[ReadAddress2];
    end else begin
      ReadBus1 <= '0;
      ReadBus2 <= '0;
    end
  end

endmodule

// File: tb/tb_row_ram_responder.sv
// Directed bench for row_ram_responder.
// Expected reads are queued at issue and compared after the edge.
module tb_row_ram_responder;

  localparam int AW = 11;
  localparam int DW = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] ReadAddress1 = '0;
  logic [AW-1:0] ReadAddress2 = '0;
  logic          WE = 1'b0;
  logic [AW-1:0] WriteReq = '0;
  logic [DW-1:0] WriteBus = '0;
  logic [DW-1:0] ReadBus1;
  logic [DW-1:0] ReadBus2;
  logic          Ready;

  row_ram_responder dut (
    .clock        (clock),
    .reset        (reset),
    .ReadAddress1 (ReadAddress1),
    .ReadAddress2 (ReadAddress2),
    .WE           (WE),
    .WriteReq     (WriteReq),
    .WriteBus     (WriteBus),
    .ReadBus1     (ReadBus1),
    .ReadBus2     (ReadBus2),
    .Ready        (Ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  logic [DW-1:0] x1, x2, x3, a5;

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic expectRd(input string tag, input int port,
                          input logic [DW-1:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, (e.port == 1) ? ReadBus1 : ReadBus2, e.val);
    end
  endtask

  task automatic sweep(input string tag);
    int n;
    bit busZero;
    n = 0;
    busZero = 1'b1;
    while (!Ready && n < 3000) begin
      step;
      n++;
      if (ReadBus1 !== '0 || ReadBus2 !== '0) busZero = 1'b0;
    end
    check({tag, "_latency"}, DW'(n), DW'(2048));
    check({tag, "_bus_zero"}, DW'(busZero), DW'(1));
  endtask

  initial begin
    x1 = {8{32'hDEAD_BEEF}};
    x2 = {16{16'h5A3C}};
    x3 = {4{64'h0123_4567_89AB_CDEF}};
    a5 = {32{8'hA5}};

    #12;
    check("rst_ready", DW'(Ready), DW'(0));
    check("rst_rb1", ReadBus1, '0);
    check("rst_rb2", ReadBus2, '0);

    WE = 1'b1;
    WriteReq = AW'(5);
    WriteBus = '1;
    reset = 1'b1;
    sweep("init");
    WE = 1'b0;
    ReadAddress1 = AW'(5);
    expectRd("row5_cleared", 1, '0);
    step;
    drain;
    check("ready_run", DW'(Ready), DW'(1));

    WE = 1'b1;
    WriteReq = AW'(10);
    WriteBus = a5;
    step;
    WE = 1'b0;
    ReadAddress1 = AW'(10);
    expectRd("wr_then_rd", 1, a5);
    step;
    drain;

    WE = 1'b1;
    WriteReq = AW'(7);
    WriteBus = DW'(16'h1234);
    ReadAddress1 = AW'(7);
    ReadAddress2 = AW'(7);
    expectRd("wt_p1", 1, DW'(16'h1234));
    expectRd("wt_p2", 2, DW'(16'h1234));
    step;
    drain;
    WE = 1'b0;
    expectRd("hold_p1", 1, DW'(16'h1234));
    expectRd("hold_p2", 2, DW'(16'h1234));
    step;
    drain;

    WE = 1'b1;
    WriteReq = AW'(20);
    WriteBus = x3;
    ReadAddress1 = AW'(21);
    ReadAddress2 = AW'(20);
    expectRd("no_interact", 1, '0);
    expectRd("wt_p2_only", 2, x3);
    step;
    drain;
    WE = 1'b0;
    ReadAddress1 = AW'(20);
    expectRd("row20_stored", 1, x3);
    step;
    drain;

    WE = 1'b1;
    WriteReq = AW'(0);
    WriteBus = x1;
    step;
    WriteReq = AW'(2047);
    WriteBus = x2;
    step;
    WE = 1'b0;
    ReadAddress1 = AW'(0);
    ReadAddress2 = AW'(2047);
    expectRd("row0", 1, x1);
    expectRd("row2047", 2, x2);
    step;
    drain;

    WE = 1'b1;
    WriteReq = AW'(3);
    WriteBus = x1;
    step;
    WriteBus = x2;
    step;
    WE = 1'b0;
    ReadAddress1 = AW'(3);
    ReadAddress2 = AW'(3);
    expectRd("b2b_p1", 1, x2);
    expectRd("b2b_p2", 2, x2);
    step;
    drain;

    reset = 1'b0;
    #1;
    check("arst_ready", DW'(Ready), DW'(0));
    check("arst_rb1", ReadBus1, '0);
    check("arst_rb2", ReadBus2, '0);
    step;
    WE = 1'b1;
    WriteReq = AW'(10);
    WriteBus = '1;
    ReadAddress1 = AW'(10);
    ReadAddress2 = AW'(7);
    reset = 1'b1;
    repeat (1000) step;
    check("mid_sweep_ready", DW'(Ready), DW'(0));
    reset = 1'b0;
    #1;
    check("mid_rst_rb1", ReadBus1, '0);
    step;
    reset = 1'b1;
    sweep("resweep");
    WE = 1'b0;
    expectRd("row10_recleared", 1, '0);
    expectRd("row7_recleared", 2, '0);
    step;
    drain;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
